rtc_write_sequencer: RTL and testbench

- Upstream stage of the RTC write-cycle FSM.
- Turns high-level requests into ordered register writes:
  - "initialise RTC" writes 3 fixed entries.
  - "set time" writes 6 time registers plus a transfer command.
- For each entry it holds address and data stable, pulses the write-cycle start input and waits for its write-end strobe.
- Drives the shared 8-bit address/data bus through the write-cycle's ad_mux select. A watchdog detects a hung write cycle.

---
 rtl/rtc_pkg.sv | 54 +++++
 rtl/rtc_seq_rom.sv | 37 +++
 rtl/rtc_write_sequencer.sv | 156 +++++++++++++++
 tb/tb_rtc_write_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC write sequencer: state encoding, table
// selector, time snapshot layout and the fixed RTC register map.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  typedef enum logic {
    SEL_INIT = 1'b0,
    SEL_SET  = 1'b1
  } seq_sel_e;

  typedef struct packed {
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic [7:0] day;
    logic [7:0] mon;
    logic [7:0] year;
  } time_t;

  // RTC register addresses
  localparam logic [7:0] ADDR_CTRL  = 8'h02;
  localparam logic [7:0] ADDR_CFG   = 8'h10;
  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DAY   = 8'h24;
  localparam logic [7:0] ADDR_MON   = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;
  localparam logic [7:0] ADDR_XFER  = 8'hF1;

  // Init data: assert control bit, release it, then write configuration
  localparam logic [7:0] INIT_D0    = 8'h10;
  localparam logic [7:0] INIT_D1    = 8'h00;
  localparam logic [7:0] INIT_D2    = 8'hD2;
  localparam logic [7:0] XFER_CMD   = 8'h00;

  localparam int INIT_LEN = 3;
  localparam int SET_LEN  = 7;

  function automatic logic [2:0] last_idx(input seq_sel_e sel);
    if (sel == SEL_INIT) last_idx = 3'(INIT_LEN - 1);
    else                 last_idx = 3'(SET_LEN - 1);
  endfunction

endpackage

// File: rtl/rtc_seq_rom.sv
// Combinational write table: maps (sequence, entry index, time snapshot)
// to the register address/data pair for that entry.
module rtc_seq_rom
  import rtc_pkg::*;
(
  input  seq_sel_e   seq_sel,
  input  logic [2:0] idx,
  input  time_t      snap,
  output logic [7:0] addr,
  output logic [7:0] data
);

  always_comb begin
    addr = 8'h00;
    data = 8'h00;
    if (seq_sel == SEL_INIT) begin
      unique case (idx)
        3'd0:    begin addr = ADDR_CTRL; data = INIT_D0; end
        3'd1:    begin addr = ADDR_CTRL; data = INIT_D1; end
        3'd2:    begin addr = ADDR_CFG;  data = INIT_D2; end
        default: begin addr = 8'h00;     data = 8'h00;   end
      endcase
    end else begin
      unique case (idx)
        3'd0:    begin addr = ADDR_SEC;  data = snap.sec;  end
        3'd1:    begin addr = ADDR_MIN;  data = snap.min;  end
        3'd2:    begin addr = ADDR_HOUR; data = snap.hour; end
        3'd3:    begin addr = ADDR_DAY;  data = snap.day;  end
        3'd4:    begin addr = ADDR_MON;  data = snap.mon;  end
        3'd5:    begin addr = ADDR_YEAR; data = snap.year; end
        3'd6:    begin addr = ADDR_XFER; data = XFER_CMD;  end
        default: begin addr = 8'h00;     data = 8'h00;     end
      endcase
    end
  end

endmodule

// File: rtl/rtc_write_sequencer.sv
// Sequences RTC init / set-time requests into single register writes handed
// to the write-cycle FSM, with a watchdog that aborts a hung write.
module rtc_write_sequencer
  import rtc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_req,
  input  logic       set_req,
  input  logic [7:0] sec_i,
  input  logic [7:0] min_i,
  input  logic [7:0] hour_i,
  input  logic [7:0] day_i,
  input  logic [7:0] mon_i,
  input  logic [7:0] year_i,
  input  logic       wc_ad_mux,
  input  logic       wc_write_end,
  output logic       wc_start,
  output logic [7:0] bus_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output state_e     dbg_state
);

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT_CYC);

  // Handshake with the write cycle: wc_start is a one-cycle request; the
  // entry is complete only when wc_write_end strobes while we sit in WAIT.
  // Strobes seen in any other state are ignored.

  state_e     state_q, state_d;
  seq_sel_e   sel_q, sel_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  time_t      snap_q, snap_d;
  logic       pend_init_q, pend_init_d;
  logic       pend_set_q, pend_set_d;
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;

  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] wd_inc;

  rtc_seq_rom u_rom (
    .seq_sel (sel_q),
    .idx     (idx_q),
    .snap    (snap_q),
    .addr    (rom_addr),
    .data    (rom_data)
  );

  assign wd_inc = wd_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    snap_d      = snap_q;
    wd_d        = wd_q;
    err_d       = err_q;
    pend_init_d = pend_init_q | init_req;
    pend_set_d  = pend_set_q | set_req;

    unique case (state_q)
      ST_IDLE: begin
        // A request arriving in the accept cycle re-arms its own flag
        if (pend_init_q) begin
          sel_d       = SEL_INIT;
          pend_init_d = init_req;
          idx_d       = 3'd0;
          err_d       = 1'b0;
          snap_d      = '{sec_i, min_i, hour_i, day_i, mon_i, year_i};
          state_d     = ST_LOAD;
        end else if (pend_set_q) begin
          sel_d       = SEL_SET;
          pend_set_d  = set_req;
          idx_d       = 3'd0;
          err_d       = 1'b0;
          snap_d      = '{sec_i, min_i, hour_i, day_i, mon_i, year_i};
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        addr_d  = rom_addr;
        data_d  = rom_data;
        state_d = ST_START;
      end
      ST_START: begin
        wd_d    = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Exit fires on reaching the limit, so the counter never wraps
        wd_d = wd_inc;
        if (wc_write_end) begin
          state_d = ST_NEXT;
        end else if (wd_inc == TIMEOUT_W) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_NEXT: begin
        if (idx_q == last_idx(sel_q)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_INIT;
      idx_q       <= 3'd0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      snap_q      <= '0;
      pend_init_q <= 1'b0;
      pend_set_q  <= 1'b0;
      wd_q        <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      snap_q      <= snap_d;
      pend_init_q <= pend_init_d;
      pend_set_q  <= pend_set_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
    end
  end

  assign wc_start  = (state_q == ST_START);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign bus_out   = wc_ad_mux ? data_q : addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Bench for rtc_write_sequencer: write-cycle model, expected-write scoreboard
// and directed init / set / priority / timeout / reset scenarios.
module tb_rtc_write_sequencer;
  import rtc_pkg::*;

  localparam int TIMEOUT_CYC = 255;
  localparam int WE_DELAY    = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_req, set_req;
  logic [7:0] sec_i, min_i, hour_i, day_i, mon_i, year_i;
  logic       wc_ad_mux, wc_write_end;
  logic       wc_start, busy, done, err;
  logic [7:0] bus_out;
  state_e     dbg_state;

  rtc_write_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .set_req(set_req),
    .sec_i(sec_i), .min_i(min_i), .hour_i(hour_i), .day_i(day_i),
    .mon_i(mon_i), .year_i(year_i), .wc_ad_mux(wc_ad_mux),
    .wc_write_end(wc_write_end), .wc_start(wc_start), .bus_out(bus_out),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  bit hang      = 1'b0;
  bit prev_done = 1'b0;
  bit wc_active = 1'b0;
  int wc_cnt    = 0;
  logic [7:0] cur_addr, cur_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- write-cycle model + monitor ----------------
  initial begin
    logic [15:0] e;
    wc_ad_mux    = 1'b0;
    wc_write_end = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
      if (done) begin
        check("busy_in_done", 32'(busy), 32'd1);
        done_cnt++;
      end
      prev_done = done;
      if (!busy) begin
        wc_active    = 1'b0;
        wc_ad_mux    = 1'b0;
        wc_write_end = 1'b0;
      end else begin
        wc_write_end = 1'b0;
        if (wc_active) begin
          wc_cnt++;
          wc_ad_mux = wc_cnt[0];
          #1;
          check("bus_mux", 32'(bus_out), 32'(wc_ad_mux ? cur_data : cur_addr));
          if (wc_cnt == WE_DELAY && !hang) begin
            wc_write_end = 1'b1;
            wc_active    = 1'b0;
            wc_ad_mux    = 1'b0;
          end
        end
        if (wc_start) begin
          start_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            wc_ad_mux = 1'b0;
            #1;
            check("write_addr", 32'(bus_out), 32'(e[15:8]));
            wc_ad_mux = 1'b1;
            #1;
            check("write_data", 32'(bus_out), 32'(e[7:0]));
            cur_addr = e[15:8];
            cur_data = e[7:0];
          end
          wc_ad_mux = 1'b0;
          wc_active = 1'b1;
          wc_cnt    = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_init();
    exp_q.push_back(16'h0210);
    exp_q.push_back(16'h0200);
    exp_q.push_back(16'h10D2);
  endtask

  task automatic push_set(input logic [7:0] s, m, h, d, mo, y);
    exp_q.push_back({8'h21, s});
    exp_q.push_back({8'h22, m});
    exp_q.push_back({8'h23, h});
    exp_q.push_back({8'h24, d});
    exp_q.push_back({8'h25, mo});
    exp_q.push_back({8'h26, y});
    exp_q.push_back(16'hF100);
  endtask

  task automatic set_time(input logic [7:0] s, m, h, d, mo, y);
    sec_i = s; min_i = m; hour_i = h; day_i = d; mon_i = mo; year_i = y;
  endtask

  task automatic pulse(input bit do_init, input bit do_set);
    @(negedge clk);
    init_req = do_init;
    set_req  = do_set;
    @(negedge clk);
    init_req = 1'b0;
    set_req  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) check("wait_done_timeout", 32'(done_cnt), 32'(target));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wc_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("wait_start_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, base_start, base_done;
    bit seen;
    rst = 1'b1;
    init_req = 1'b0;
    set_req  = 1'b0;
    set_time(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(wc_start), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bus", 32'(bus_out), 32'h00);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Init path, including request-to-start latency
    push_init();
    @(negedge clk);
    init_req = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      init_req = 1'b0;
      n++;
      if (wc_start) break;
    end
    check("start_latency", 32'(n), 32'd3);
    wait_done(1);
    check("init_starts", 32'(start_cnt), 32'd3);
    check("init_done", 32'(done_cnt), 32'd1);
    check("init_q_empty", 32'(exp_q.size()), 32'd0);

    // Set path: inputs change after acceptance, snapshot must hold
    set_time(8'h45, 8'h30, 8'h12, 8'h07, 8'h09, 8'h16);
    push_set(8'h45, 8'h30, 8'h12, 8'h07, 8'h09, 8'h16);
    pulse(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    set_time(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_done(2);
    check("set_starts", 32'(start_cnt), 32'd10);
    check("set_done", 32'(done_cnt), 32'd2);
    check("set_q_empty", 32'(exp_q.size()), 32'd0);

    // Simultaneous requests: init first, then set
    set_time(8'h59, 8'h58, 8'h23, 8'h31, 8'h12, 8'h99);
    push_init();
    push_set(8'h59, 8'h58, 8'h23, 8'h31, 8'h12, 8'h99);
    pulse(1'b1, 1'b1);
    wait_done(4);
    check("both_starts", 32'(start_cnt), 32'd20);
    check("both_done", 32'(done_cnt), 32'd4);
    check("both_q_empty", 32'(exp_q.size()), 32'd0);

    // Random time values through the set path
    for (int r = 0; r < 2; r++) begin
      logic [7:0] t[6];
      for (int j = 0; j < 6; j++) t[j] = 8'($urandom_range(0, 255));
      set_time(t[0], t[1], t[2], t[3], t[4], t[5]);
      push_set(t[0], t[1], t[2], t[3], t[4], t[5]);
      pulse(1'b0, 1'b1);
      wait_done(5 + r);
    end
    check("rand_q_empty", 32'(exp_q.size()), 32'd0);

    // Timeout: write cycle never completes
    hang = 1'b1;
    base_done = done_cnt;
    exp_q.push_back(16'h0210);
    pulse(1'b1, 1'b0);
    wait_start(seen);
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      if (!err) n++;
    end
    check("timeout_cycles", 32'(n), 32'(TIMEOUT_CYC));
    check("timeout_state", 32'(dbg_state), 32'(ST_ERR));
    @(negedge clk);
    check("timeout_idle", 32'(busy), 32'd0);
    check("timeout_err_sticky", 32'(err), 32'd1);
    check("timeout_no_done", 32'(done_cnt), 32'(base_done));
    hang = 1'b0;
    repeat (3) @(negedge clk);

    // Recovery clears err and completes
    push_init();
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("err_cleared", 32'(err), 32'd0);
    wait_done(base_done + 1);
    check("recover_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset during the 4th set entry
    set_time(8'h11, 8'h22, 8'h33, 8'h04, 8'h05, 8'h06);
    push_set(8'h11, 8'h22, 8'h33, 8'h04, 8'h05, 8'h06);
    pulse(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) wait_start(seen);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_start", 32'(wc_start), 32'd0);
    check("mid_rst_bus", 32'(bus_out), 32'h00);
    check("mid_rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    base_start = start_cnt;
    repeat (40) @(negedge clk);
    check("no_writes_after_rst", 32'(start_cnt), 32'(base_start));
    check("idle_after_rst", 32'(dbg_state), 32'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
